// File: rtl/dmem_if.sv
// Request/response bus between a load-store stage and dmem_unit.
// One outstanding request; the response is a single-cycle strobe.
interface dmem_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_mode;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_mode, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_mode, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_unit.sv
// Byte-addressed data memory with sized/extended loads, fault
// detection and a fixed response latency of WAIT_STATES+1 cycles.
module dmem_unit #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WLAST =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [2:0]    mode_q;
  logic          we_q;
  logic          flt_q;
  logic          valid_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic [7:0]    mem [DEPTH];

  function automatic logic faulted(
    logic we, logic [ADDR_W-1:0] a, logic [2:0] m);
    logic [2:0] sz;
    logic       bad;
    sz  = 3'd1;
    bad = 1'b0;
    unique case (m)
      3'b000, 3'b011: sz = 3'd1;
      3'b001, 3'b100: begin
        sz  = 3'd2;
        bad = a[0];
      end
      3'b010: begin
        sz  = 3'd4;
        bad = |a[1:0];
      end
      default: bad = 1'b1;
    endcase
    if (we && m > 3'b010) bad = 1'b1;
    return bad || (({1'b0, a} + {{(ADDR_W-2){1'b0}}, sz}) > DEPTH_X);
  endfunction

  function automatic logic [AW-1:0] ix(
    logic [AW-1:0] a, logic [1:0] off);
    return a + AW'(off);
  endfunction

  function automatic logic [31:0] extend(
    logic [2:0] m, logic [31:0] w);
    logic [31:0] r;
    r = 32'd0;
    unique case (1'b1)
      m == 3'b000: r = {{24{w[7]}}, w[7:0]};
      m == 3'b001: r = {{16{w[15]}}, w[15:0]};
      m == 3'b010: r = w;
      m == 3'b011: r = {24'd0, w[7:0]};
      m == 3'b100: r = {16'd0, w[15:0]};
      default:     r = 32'd0;
    endcase
    return r;
  endfunction

  logic          acc;
  logic          req_flt;
  logic          idle;
  logic [AW-1:0] wa;
  logic [AW-1:0] ra;
  logic [2:0]    rm;
  logic          rskip;
  logic [31:0]   word;
  logic [31:0]   rsp_d;

  assign idle    = (state_q == S_IDLE);
  assign acc     = bus.req_valid && idle;
  assign req_flt = faulted(bus.req_we, bus.req_addr, bus.req_mode);
  assign wa      = bus.req_addr[AW-1:0];

  // With no wait states the response is built from the live request.
  assign ra    = idle ? wa : addr_q;
  assign rm    = idle ? bus.req_mode : mode_q;
  assign rskip = idle ? (bus.req_we || req_flt) : (we_q || flt_q);
  assign word  = {mem[ix(ra, 2'd3)], mem[ix(ra, 2'd2)],
                  mem[ix(ra, 2'd1)], mem[ra]};
  assign rsp_d = rskip ? 32'd0 : extend(rm, word);

  always_ff @(posedge clk) begin
    if (acc && bus.req_we && !req_flt) begin
      mem[wa] <= bus.req_wdata[7:0];
      if (bus.req_mode != 3'b000)
        mem[ix(wa, 2'd1)] <= bus.req_wdata[15:8];
      if (bus.req_mode == 3'b010) begin
        mem[ix(wa, 2'd2)] <= bus.req_wdata[23:16];
        mem[ix(wa, 2'd3)] <= bus.req_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      mode_q  <= 3'd0;
      we_q    <= 1'b0;
      flt_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (acc) begin
            addr_q <= wa;
            mode_q <= bus.req_mode;
            we_q   <= bus.req_we;
            flt_q  <= req_flt;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
              valid_q <= 1'b1;
              rdata_q <= rsp_d;
              err_q   <= req_flt;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'd0;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == WLAST) begin
            state_q <= S_RESP;
            cnt_q   <= 4'd0;
            valid_q <= 1'b1;
            rdata_q <= rsp_d;
            err_q   <= flt_q;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = idle;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit: one instance with no wait states,
// one with three, sharing the clock but with separate resets.
module tb_dmem_unit;
  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst3_n = 1'b0;
  int total = 0;
  int bad = 0;
  int pulses;

  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(32)) b0 ();
  dmem_if #(.ADDR_W(32)) b3 ();

  dmem_unit #(.DEPTH(1024), .ADDR_W(32), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst0_n), .bus(b0.slave));
  dmem_unit #(.DEPTH(1024), .ADDR_W(32), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst3_n), .bus(b3.slave));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit d, bit v, bit we, logic [31:0] a,
                       logic [2:0] m, logic [31:0] wd);
    if (d) begin
      b3.req_valid = v; b3.req_we = we; b3.req_addr = a;
      b3.req_mode = m; b3.req_wdata = wd;
    end else begin
      b0.req_valid = v; b0.req_we = we; b0.req_addr = a;
      b0.req_mode = m; b0.req_wdata = wd;
    end
  endtask

  function automatic logic rv(bit d);
    return d ? b3.rsp_valid : b0.rsp_valid;
  endfunction

  task automatic xact(string tag, bit d, bit we, logic [31:0] a,
                      logic [2:0] m, logic [31:0] wd,
                      logic [31:0] exp_rd, logic exp_err);
    int lat;
    logic [31:0] rd;
    logic er;
    @(negedge clk);
    drive(d, 1'b1, we, a, m, wd);
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    lat = 1;
    while (!rv(d) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = d ? b3.rsp_rdata : b0.rsp_rdata;
    er = d ? b3.rsp_err : b0.rsp_err;
    chk($sformatf("%s.lat", tag), 32'(lat), d ? 32'd4 : 32'd1);
    chk($sformatf("%s.rdata", tag), rd, exp_rd);
    chk($sformatf("%s.err", tag), 32'(er), 32'(exp_err));
    @(posedge clk); #1;
    chk($sformatf("%s.strobe", tag), 32'(rv(d)), 32'd0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 32'(b0.rsp_valid), 32'd0);
    chk("rst.rdata", b0.rsp_rdata, 32'd0);
    chk("rst.err", 32'(b0.rsp_err), 32'd0);
    @(negedge clk);
    rst0_n = 1'b1;
    rst3_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.ready0", 32'(b0.req_ready), 32'd1);
    chk("rst.ready3", 32'(b3.req_ready), 32'd1);

    xact("st_w10", 0, 1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0);
    xact("ld_w10", 0, 0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);
    xact("ld_b13", 0, 0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 0);
    xact("ld_ub13", 0, 0, 32'h13, 3'b011, 32'h0, 32'h000000DE, 0);
    xact("ld_h12", 0, 0, 32'h12, 3'b001, 32'h0, 32'hFFFFDEAD, 0);
    xact("ld_uh10", 0, 0, 32'h10, 3'b100, 32'h0, 32'h0000BEEF, 0);

    xact("f_ldw11", 0, 0, 32'h11, 3'b010, 32'h0, 32'h0, 1);
    xact("st_w20", 0, 1, 32'h20, 3'b010, 32'h11223344, 32'h0, 0);
    xact("f_sth21", 0, 1, 32'h21, 3'b001, 32'h0000AAAA, 32'h0, 1);
    xact("ld_w20", 0, 0, 32'h20, 3'b010, 32'h0, 32'h11223344, 0);
    xact("f_m101", 0, 0, 32'h10, 3'b101, 32'h0, 32'h0, 1);
    xact("f_stub", 0, 1, 32'h10, 3'b011, 32'h00000055, 32'h0, 1);
    xact("f_st101", 0, 1, 32'h10, 3'b101, 32'h00000066, 32'h0, 1);
    xact("ld_w10b", 0, 0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);

    xact("st_h3fe", 0, 1, 32'h3FE, 3'b001, 32'h00008001, 32'h0, 0);
    xact("f_stw3fe", 0, 1, 32'h3FE, 3'b010, 32'hFFFFFFFF, 32'h0, 1);
    xact("f_ldw3fe", 0, 0, 32'h3FE, 3'b010, 32'h0, 32'h0, 1);
    xact("ld_uh3fe", 0, 0, 32'h3FE, 3'b100, 32'h0, 32'h00008001, 0);
    xact("ld_h3fe", 0, 0, 32'h3FE, 3'b001, 32'h0, 32'hFFFF8001, 0);
    xact("ld_ub3ff", 0, 0, 32'h3FF, 3'b011, 32'h0, 32'h00000080, 0);
    xact("f_ldw400", 0, 0, 32'h400, 3'b010, 32'h0, 32'h0, 1);
    xact("f_ldb_hi", 0, 0, 32'h80000010, 3'b000, 32'h0, 32'h0, 1);

    xact("st3_w8", 1, 1, 32'h8, 3'b010, 32'hCAFEF00D, 32'h0, 0);

    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h8, 3'b010, 32'h0);
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("busy.ready%0d", k), 32'(b3.req_ready), 32'd0);
      chk($sformatf("busy.valid%0d", k), 32'(b3.rsp_valid),
          (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) chk("busy.rdata", b3.rsp_rdata, 32'hCAFEF00D);
      else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    chk("busy.ready5", 32'(b3.req_ready), 32'd1);
    chk("busy.valid5", 32'(b3.rsp_valid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (b3.rsp_valid) pulses++;
    end
    chk("busy.no_extra", 32'(pulses), 32'd0);

    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'h40, 3'b010, 32'h12345678);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    @(posedge clk); #1;
    rst3_n = 1'b0;
    #1;
    chk("rstw.async_valid", 32'(b3.rsp_valid), 32'd0);
    chk("rstw.async_ready", 32'(b3.req_ready), 32'd1);
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (b3.rsp_valid) pulses++;
    end
    @(negedge clk);
    rst3_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (b3.rsp_valid) pulses++;
    end
    chk("rstw.dropped", 32'(pulses), 32'd0);
    chk("rstw.ready", 32'(b3.req_ready), 32'd1);
    xact("ld3_w40", 1, 0, 32'h40, 3'b010, 32'h0, 32'h12345678, 0);

    xact("st3_b41", 1, 1, 32'h41, 3'b000, 32'h000000AB, 32'h0, 0);
    xact("ld3_w40b", 1, 0, 32'h40, 3'b010, 32'h0, 32'h1234AB78, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
